// File: rtl/ota_trim_cal.sv
// SAR offset-trim calibration controller for an array of OTAs.
// Holds per-channel trim codes and supports manual write/readback and abort-restore.
//
// state  | meaning
// IDLE   | waiting for start; manual trim writes accepted
// SETUP  | back up channel code, load midscale, clear channel sat flag
// WAIT   | settle timer counting down to terminal count
// DECIDE | resolve current bit from comparator, arm next lower bit
// NEXT   | flag saturation, advance channel or finish with done
module ota_trim_cal #(
    parameter int NCH    = 4,
    parameter int TRIM_W = 6,
    parameter int SETTLE = 16,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    cal_all,
    input  logic [CH_W-1:0]         cal_ch,
    input  logic                    abort,
    input  logic [NCH-1:0]          cmp_in,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [TRIM_W-1:0]       wr_data,
    input  logic [CH_W-1:0]         rd_ch,
    output logic [TRIM_W-1:0]       rd_data,
    output logic [NCH*TRIM_W-1:0]   trim_out,
    output logic                    busy,
    output logic                    done,
    output logic [CH_W-1:0]         active_ch,
    output logic [NCH-1:0]          sat
);
    localparam int BI_W  = $clog2(TRIM_W);
    localparam int CNT_W = $clog2(SETTLE);
    localparam logic [TRIM_W-1:0] MID = {1'b1, {(TRIM_W-1){1'b0}}};

    if (SETTLE < 3) begin : g_settle_chk
        $error("ota_trim_cal: SETTLE must be >= 3");
    end

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_DECIDE, S_NEXT} state_t;

    state_t              state, state_nxt;
    logic [TRIM_W-1:0]   trim [NCH];
    logic [TRIM_W-1:0]   backup;
    logic [TRIM_W-1:0]   code_cur;
    logic [TRIM_W-1:0]   code_dec;
    logic [BI_W-1:0]     bit_idx;
    logic [CNT_W-1:0]    cnt;
    logic [NCH-1:0]      cmp_m, cmp_s;
    logic                mode_all;
    logic                start_ok, wr_ok, abort_hit, more_ch, cmp_bit;

    assign start_ok  = start && (cal_all || (32'(cal_ch) < NCH));
    assign wr_ok     = wr_en && (32'(wr_ch) < NCH);
    assign abort_hit = abort && (state != S_IDLE);
    assign more_ch   = mode_all && (32'(active_ch) < NCH - 1);
    assign code_cur  = trim[active_ch];
    assign cmp_bit   = cmp_s[active_ch];
    assign rd_data   = (32'(rd_ch) < NCH) ? trim[rd_ch] : '0;

    for (genvar i = 0; i < NCH; i++) begin : g_out
        assign trim_out[i*TRIM_W +: TRIM_W] = trim[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_m <= '0;
            cmp_s <= '0;
        end else begin
            cmp_m <= cmp_in;
            cmp_s <= cmp_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_ok) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_WAIT;
            S_WAIT:   if (cnt == '0) state_nxt = S_DECIDE;
            S_DECIDE: state_nxt = (bit_idx == '0) ? S_NEXT : S_WAIT;
            S_NEXT:   state_nxt = more_ch ? S_SETUP : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort_hit) state_nxt = S_IDLE;
    end

    // Comparator high means the code is too large: drop the bit under test.
    always_comb begin
        code_dec = code_cur;
        if (cmp_bit) code_dec[bit_idx] = 1'b0;
        if (bit_idx != '0) code_dec[bit_idx - 1'b1] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) trim[i] <= MID;
            backup    <= '0;
            bit_idx   <= '0;
            cnt       <= '0;
            mode_all  <= 1'b0;
            active_ch <= '0;
            sat       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_hit) begin
                busy <= 1'b0;
                // In SETUP the backup still belongs to the previous channel.
                if (state != S_SETUP) trim[active_ch] <= backup;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (wr_ok) trim[wr_ch] <= wr_data;
                        if (start_ok) begin
                            mode_all  <= cal_all;
                            active_ch <= cal_all ? '0 : cal_ch;
                            busy      <= 1'b1;
                        end
                    end
                    S_SETUP: begin
                        backup          <= code_cur;
                        trim[active_ch] <= MID;
                        bit_idx         <= BI_W'(TRIM_W - 1);
                        sat[active_ch]  <= 1'b0;
                        cnt             <= CNT_W'(SETTLE - 1);
                    end
                    S_WAIT: begin
                        if (cnt != '0) cnt <= cnt - 1'b1;
                    end
                    S_DECIDE: begin
                        trim[active_ch] <= code_dec;
                        if (bit_idx != '0) begin
                            bit_idx <= bit_idx - 1'b1;
                            cnt     <= CNT_W'(SETTLE - 1);
                        end
                    end
                    S_NEXT: begin
                        sat[active_ch] <= (code_cur == '0) || (code_cur == '1);
                        if (more_ch) begin
                            active_ch <= active_ch + 1'b1;
                        end else begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
